qft_readout: RTL and testbench

- Downstream consumer of the 3-qubit QFT combinational core.
- On a start pulse it snapshots the 8 complex output coefficients and computes |c|^2 for each basis state sequentially.
- It tracks the most probable state and the total probability, then streams all 16 coefficient words out over a valid/ready interface.
- This replaces the fixed-index combinational readout used today with a sequential, back-pressurable readout.

---
 rtl/qft_pkg.sv | 22 ++
 rtl/qft_mag_sq.sv | 23 ++
 rtl/qft_readout.sv | 115 +++++++++++
 tb/tb_qft_readout.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/qft_pkg.sv
// Shared types and constants for the 3-qubit QFT datapath and its consumers.
// Coefficients are signed Q2.15. Probabilities are unsigned with 15 fractional bits.
package qft_pkg;

  localparam int COEF_W   = 17;
  localparam int FRAC     = 15;
  localparam int N_STATES = 8;
  localparam int IDX_W    = 3;
  localparam int WORD_W   = 4;
  localparam int PROB_W   = 19;
  localparam int TOT_W    = 22;

  localparam logic signed [COEF_W-1:0] ONE       = 17'sd32768;
  localparam logic signed [COEF_W-1:0] INV_SQRT2 = 17'sd23170;

  typedef enum logic [1:0] {IDLE, SCAN, STREAM, FIN} state_e;

  // Element [s][0] is the real part of state s and [s][1] is the imaginary part.
  // This matches the flat coef_in layout bit for bit.
  typedef logic [N_STATES-1:0][1:0][COEF_W-1:0] coef_bus_t;

endpackage

// File: rtl/qft_mag_sq.sv
// Squared magnitude of one complex Q2.15 coefficient, truncated back to 15 fractional bits.
module qft_mag_sq
  import qft_pkg::*;
(
  input  logic signed [COEF_W-1:0] re,
  input  logic signed [COEF_W-1:0] im,
  output logic [PROB_W-1:0]        mag_sq
);

  localparam int SQ_W = 2 * COEF_W + 1;

  logic signed [SQ_W-1:0] re_x;
  logic signed [SQ_W-1:0] im_x;
  logic signed [SQ_W-1:0] sq_sum;

  assign re_x   = SQ_W'(re);
  assign im_x   = SQ_W'(im);
  assign sq_sum = re_x * re_x + im_x * im_x;

  // The sum is never negative. The largest value, 2 * 65536^2, shifted down by 15 still fits in PROB_W.
  assign mag_sq = PROB_W'(sq_sum >>> FRAC);

endmodule

// File: rtl/qft_readout.sv
// Sequential readout of the QFT output: capture, scan |c|^2 for max/total, then
// stream 16 coefficient words over valid/ready.
module qft_readout
  import qft_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [N_STATES*2*COEF_W-1:0]   coef_in,
  output logic                           busy,
  output logic                           done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_state,
  output logic                           out_im,
  output logic [COEF_W-1:0]              out_data,
  output logic [IDX_W-1:0]               max_state,
  output logic [PROB_W-1:0]              max_prob,
  output logic [TOT_W-1:0]               total_prob
);

  state_e            state_q, state_d;
  coef_bus_t         cap_q, cap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  max_state_q, max_state_d;
  logic [PROB_W-1:0] max_prob_q, max_prob_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic [PROB_W-1:0] p_cur;

  qft_mag_sq u_mag_sq (
    .re     ($signed(cap_q[idx_q][0])),
    .im     ($signed(cap_q[idx_q][1])),
    .mag_sq (p_cur)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and a latch cannot be inferred.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    word_d      = word_q;
    max_state_d = max_state_q;
    max_prob_d  = max_prob_q;
    total_d     = total_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_d       = coef_in;
          idx_d       = '0;
          max_state_d = '0;
          max_prob_d  = '0;
          total_d     = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        total_d = total_q + TOT_W'(p_cur);
        // A strict compare keeps the lowest index on a tie.
        if (idx_q == '0 || p_cur > max_prob_q) begin
          max_state_d = idx_q;
          max_prob_d  = p_cur;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N_STATES - 1)) begin
          word_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          word_d = word_q + 1'b1;
          if (word_q == {WORD_W{1'b1}}) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments, so every flop samples values from before the edge.
  // NOTE: the capture register is reset along with the control state, so a reset abort leaves no stale coefficients.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      max_state_q <= '0;
      max_prob_q  <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      max_state_q <= max_state_d;
      max_prob_q  <= max_prob_d;
      total_q     <= total_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign out_valid  = (state_q == STREAM);
  // The word fields are held at zero outside STREAM.
  // Inside STREAM they depend only on word_q, so they stay stable during a stall.
  assign out_state  = out_valid ? word_q[WORD_W-1:1] : '0;
  assign out_im     = out_valid ? word_q[0] : 1'b0;
  assign out_data   = out_valid ? cap_q[word_q[WORD_W-1:1]][word_q[0]] : '0;
  assign max_state  = max_state_q;
  assign max_prob   = max_prob_q;
  assign total_prob = total_q;

endmodule

// File: tb/tb_qft_readout.sv
// Randomised self-checking bench for qft_readout.
// The reference model works from plain integer arithmetic on the coefficient lists.
module tb_qft_readout;
  import qft_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic                         out_ready = 1'b0;
  logic [N_STATES*2*COEF_W-1:0] coef_in = '0;
  logic                         busy, done, out_valid, out_im;
  logic [IDX_W-1:0]             out_state, max_state;
  logic [COEF_W-1:0]            out_data;
  logic [PROB_W-1:0]            max_prob;
  logic [TOT_W-1:0]             total_prob;

  qft_readout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .coef_in    (coef_in),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_state  (out_state),
    .out_im     (out_im),
    .out_data   (out_data),
    .max_state  (max_state),
    .max_prob   (max_prob),
    .total_prob (total_prob)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int re_m[N_STATES];
  int im_m[N_STATES];

  function automatic int pick_pool();
    int pool[5] = '{0, 11585, -11585, 23170, -65536};
    return pool[$urandom_range(0, 4)];
  endfunction

  // Modes: 0 is the QFT of |000>, 1 is state 3 alone, 2 is extreme values, 3 is fully random, 4 is a small pool that produces ties.
  task automatic set_coefs(input int mode);
    for (int s = 0; s < N_STATES; s++) begin
      case (mode)
        0: begin re_m[s] = 11585; im_m[s] = 0; end
        1: begin re_m[s] = (s == 3) ? -23170 : 0; im_m[s] = (s == 3) ? 23170 : 0; end
        2: begin re_m[s] = -65536; im_m[s] = -65536; end
        3: begin re_m[s] = int'($urandom_range(0, 131071)) - 65536;
                 im_m[s] = int'($urandom_range(0, 131071)) - 65536; end
        default: begin re_m[s] = pick_pool(); im_m[s] = pick_pool(); end
      endcase
    end
  endtask

  function automatic longint prob(input int r, input int i);
    return (longint'(r) * r + longint'(i) * i) / 32768;
  endfunction

  function automatic logic [N_STATES*2*COEF_W-1:0] rand_bus();
    logic [N_STATES*2*COEF_W-1:0] b;
    for (int k = 0; k < N_STATES * 2 * COEF_W; k += 16) b[k +: 16] = 16'($urandom);
    return b;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, longint'({busy, done, out_valid, out_state, out_im, out_data}), 0);
    check({tag, "_res"}, longint'({max_state, max_prob, total_prob}), 0);
  endtask

  task automatic run_txn(input int ready_pct, input bit repulse, input int reset_rel);
    logic [N_STATES*2*COEF_W-1:0] bus;
    longint exp_words[$];
    longint p[N_STATES];
    longint exp_tot, exp_mp;
    int     exp_ms, c0, rel, widx, done_cnt;
    bit     finished, first_v;
    exp_tot = 0; exp_mp = 0; exp_ms = 0;
    widx = 0; done_cnt = 0; finished = 0; first_v = 0;
    for (int s = 0; s < N_STATES; s++) begin
      p[s] = prob(re_m[s], im_m[s]);
      exp_tot += p[s];
      if (p[s] > exp_mp) exp_mp = p[s];
      bus[34*s +: 17]      = 17'(re_m[s]);
      bus[34*s + 17 +: 17] = 17'(im_m[s]);
      exp_words.push_back((longint'(s) << 18) | (longint'(re_m[s]) & 64'h1FFFF));
      exp_words.push_back((longint'(s) << 18) | (64'd1 << 17) | (longint'(im_m[s]) & 64'h1FFFF));
    end
    // The winning state is the first index that reaches the maximum probability.
    for (int s = N_STATES - 1; s >= 0; s--) if (p[s] == exp_mp) exp_ms = s;

    @(negedge clk);
    start = 1'b1; coef_in = bus; c0 = cyc;
    for (int n = 0; n < 3000 && !finished; n++) begin
      @(negedge clk);
      rel = cyc - c0;
      start   = repulse && (rel == 5 || rel == 12);
      coef_in = rand_bus();
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (rel == reset_rel) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_abort");
        @(negedge clk);
        check("no_done_after_abort", longint'(done) + done_cnt, 0);
        rst_n = 1'b1; start = 1'b0;
        return;
      end
      if (rel >= 1 && rel <= 8) check("scan_phase", longint'({busy, out_valid, done}), 4);
      if (out_valid) begin
        if (!first_v) begin
          first_v = 1'b1;
          check("first_valid_cycle", rel, 9);
          check("max_state", max_state, exp_ms);
          check("max_prob", max_prob, exp_mp);
          check("total_prob", total_prob, exp_tot);
        end
        if (widx >= 16) check("extra_word", widx, 15);
        else check($sformatf("word%0d", widx), longint'({out_state, out_im, out_data}), exp_words[widx]);
        if (out_ready) widx++;
      end
      if (done) begin
        done_cnt++;
        check("done_after_16", widx, 16);
        check("done_busy", busy, 1);
        if (ready_pct >= 100) check("done_cycle", rel, 25);
      end else if (done_cnt > 0 && !busy) begin
        check("done_once", done_cnt, 1);
        if (ready_pct >= 100) check("idle_cycle", rel, 26);
        check("hold_result", longint'({max_state, max_prob, total_prob}),
              (longint'(exp_ms) << 41) | (exp_mp << 22) | exp_tot);
        finished = 1'b1;
      end
    end
    if (!finished) check("timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
    set_coefs(0); run_txn(100, 1'b0, -1);
    set_coefs(1); run_txn(100, 1'b0, -1);
    set_coefs(2); run_txn(100, 1'b0, -1);
    set_coefs(3); run_txn(50, 1'b0, -1);
    set_coefs(4); run_txn(30, 1'b0, -1);
    set_coefs(3); run_txn(100, 1'b1, -1);
    set_coefs(3); run_txn(100, 1'b0, 15);
    set_coefs(4); run_txn(100, 1'b0, -1);
    for (int k = 0; k < 6; k++) begin
      set_coefs(3 + (k % 2));
      run_txn(int'($urandom_range(20, 100)), 1'(k % 2), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
